// File: rtl/ob_ingress_arb_pkg.sv
// Shared order-book types: command word, port-tagged command, port-count limits.
// Latency: n/a (types and constants only).
// Backpressure: n/a.
package ob_ingress_arb_pkg;

    localparam int OB_INGRESS_P_MAX = 16;

    typedef struct packed {
        logic [1:0]  op;
        logic        side;
        logic [7:0]  id;
        logic [15:0] price;
        logic [11:0] qty;
    } cmd_t;

    // Command tagged with the ingress port it arrived on, consumed by ob_cntrl.
    typedef struct packed {
        logic [$clog2(OB_INGRESS_P_MAX)-1:0] port;
        cmd_t                                cmd;
    } ob_tagged_cmd_t;

    // Port index width; a single-port build still carries a 1-bit port field.
    function automatic int port_w(input int p);
        return (p > 1) ? $clog2(p) : 1;
    endfunction

endpackage

// File: rtl/ob_ingress_arb_if.sv
// Ingress bundle: per-port push/flush/status plus the arbitrated command output.
// Latency: n/a (wiring only).
// Backpressure: cmd_full_r per port toward sources, cmd_out_pop from the consumer.
interface ob_ingress_arb_if #(
    parameter int P = 4,
    parameter int N = 4
) ();
    import ob_ingress_arb_pkg::*;

    localparam int OW = $clog2(N + 1);
    localparam int PW = port_w(P);

    logic [P-1:0]          cmd_vld_r;
    cmd_t [P-1:0]          cmd_r;
    logic [P-1:0]          cmd_full_r;
    logic [P-1:0]          flush;
    logic                  cmd_out_vld;
    cmd_t                  cmd_out;
    logic [PW-1:0]         cmd_out_port;
    logic                  cmd_out_pop;
    logic [P-1:0][OW-1:0]  occ_r;
    logic [P-1:0]          ovfl_r;
    logic                  ovfl_clr;

    modport master (
        output cmd_vld_r, cmd_r, flush, cmd_out_pop, ovfl_clr,
        input  cmd_full_r, cmd_out_vld, cmd_out, cmd_out_port, occ_r, ovfl_r
    );

    modport slave (
        input  cmd_vld_r, cmd_r, flush, cmd_out_pop, ovfl_clr,
        output cmd_full_r, cmd_out_vld, cmd_out, cmd_out_port, occ_r, ovfl_r
    );

endinterface

// File: rtl/ob_ingress_arb_port_q.sv
// One ingress port FIFO: N x cmd_t with occupancy, registered full, sticky overflow, flush.
// Latency: head visible the cycle after the push edge (no output register).
// Backpressure: full_r registered from next occupancy; pushes into a full FIFO without a pop are dropped.
module ob_ingress_arb_port_q
    import ob_ingress_arb_pkg::*;
#(
    parameter  int N    = 4,
    parameter  int SKID = 1,
    localparam int AW   = $clog2(N),
    localparam int OW   = $clog2(N + 1)
) (
    input  logic          clk,
    input  logic          rst,
    input  logic          push,
    input  cmd_t          push_dat,
    input  logic          pop,
    input  logic          flush,
    input  logic          ovfl_clr,
    output cmd_t          head,
    output logic [OW-1:0] occ,
    output logic          full_r,
    output logic          ovfl_r
);

    cmd_t          mem [N];
    logic [AW-1:0] wr_ptr;
    logic [AW-1:0] rd_ptr;
    logic          pop_ok;
    logic          is_full;
    logic          push_ok;
    logic          ovfl_set;
    logic [OW-1:0] occ_next;

    // Flush voids both push and pop; a full FIFO still takes a push when it is popped the same cycle.
    always_comb begin
        pop_ok   = pop && !flush && (occ != '0);
        is_full  = (occ == OW'(N));
        push_ok  = push && !flush && (!is_full || pop_ok);
        ovfl_set = push && !flush && is_full && !pop_ok;
        occ_next = flush ? '0 : (occ + OW'(push_ok) - OW'(pop_ok));
    end

    // Pointer, occupancy and status state; overflow set wins over a same-cycle clear.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            occ    <= '0;
            full_r <= 1'b0;
            ovfl_r <= 1'b0;
        end else begin
            occ    <= occ_next;
            full_r <= (occ_next >= OW'(N - SKID));
            ovfl_r <= ovfl_set | (ovfl_r & ~ovfl_clr);
            if (flush) begin
                wr_ptr <= '0;
                rd_ptr <= '0;
            end else begin
                if (push_ok) wr_ptr <= wr_ptr + 1'b1;
                if (pop_ok)  rd_ptr <= rd_ptr + 1'b1;
            end
        end
    end

    // Storage write; contents are meaningless while occ is zero, so no reset.
    always_ff @(posedge clk) begin
        if (push_ok) mem[wr_ptr] <= push_dat;
    end

    assign head = mem[rd_ptr];

endmodule

// File: rtl/ob_ingress_arb.sv
// Multi-port command ingress: P per-port FIFOs feeding a round-robin arbiter toward ob_cntrl.
// Latency: zero from FIFO head to cmd_out (grant is combinational from registered occupancy).
// Backpressure: per-port registered cmd_full_r; output held until cmd_out_pop.
module ob_ingress_arb
    import ob_ingress_arb_pkg::*;
#(
    parameter int P    = 4,
    parameter int N    = 4,
    parameter int SKID = 1
) (
    input  logic             clk,
    input  logic             rst,
    ob_ingress_arb_if.slave  io
);

    localparam int PW = port_w(P);

    logic [PW-1:0] rr_ptr;
    logic [PW-1:0] grant;
    logic          found;
    logic [P-1:0]  ne;
    logic [P-1:0]  pop_vec;
    cmd_t          heads [P];

    for (genvar i = 0; i < P; i++) begin : g_port
        ob_ingress_arb_port_q #(
            .N    (N),
            .SKID (SKID)
        ) u_q (
            .clk      (clk),
            .rst      (rst),
            .push     (io.cmd_vld_r[i]),
            .push_dat (io.cmd_r[i]),
            .pop      (pop_vec[i]),
            .flush    (io.flush[i]),
            .ovfl_clr (io.ovfl_clr),
            .head     (heads[i]),
            .occ      (io.occ_r[i]),
            .full_r   (io.cmd_full_r[i]),
            .ovfl_r   (io.ovfl_r[i])
        );
        assign ne[i] = (io.occ_r[i] != '0);
    end

    // First non-empty port at or after rr_ptr, wrapping upward.
    always_comb begin
        grant = '0;
        found = 1'b0;
        for (int k = 0; k < P; k++) begin
            if (!found && ne[(int'(rr_ptr) + k) % P]) begin
                grant = PW'((int'(rr_ptr) + k) % P);
                found = 1'b1;
            end
        end
    end

    // Route the consumer's pop to the granted port only; a pop with nothing presented does nothing.
    always_comb begin
        pop_vec = '0;
        if (io.cmd_out_pop && found) pop_vec[grant] = 1'b1;
    end

    // Round-robin pointer moves past the granted port on an effective pop; a flushed grant leaves it put.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            rr_ptr <= '0;
        end else if (io.cmd_out_pop && found && !io.flush[grant]) begin
            rr_ptr <= (grant == PW'(P - 1)) ? '0 : grant + 1'b1;
        end
    end

    assign io.cmd_out_vld  = found;
    assign io.cmd_out_port = grant;
    assign io.cmd_out      = found ? heads[grant] : '0;

    pop_without_vld: assert property (@(posedge clk) disable iff (rst)
        !(io.cmd_out_pop && !io.cmd_out_vld));

endmodule

// File: tb/tb_ob_ingress_arb.sv
module tb_ob_ingress_arb;
    import ob_ingress_arb_pkg::*;

    localparam int P    = 4;
    localparam int N    = 4;
    localparam int SKID = 1;

    logic clk = 1'b0;
    logic rst;
    always #5 clk = ~clk;

    ob_ingress_arb_if #(.P(P), .N(N)) io ();

    ob_ingress_arb #(.P(P), .N(N), .SKID(SKID)) dut (
        .clk (clk),
        .rst (rst),
        .io  (io.slave)
    );

    int         checks = 0;
    int         errors = 0;
    cmd_t       exp_q [P][$];
    logic [P-1:0] ovfl_m;
    int         rr_m;
    int         seq;
    cmd_t       hold_cmd;

    task automatic check(input string tag, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", tag, act, exp);
        end
    endtask

    function automatic cmd_t mk(input int p, input int s);
        cmd_t c;
        c.op    = 2'(s);
        c.side  = s[0];
        c.id    = {p[3:0], s[3:0]};
        c.price = 16'(16'h1000 + s * 7);
        c.qty   = 12'(s * 3 + p);
        return c;
    endfunction

    function automatic int exp_grant();
        for (int k = 0; k < P; k++)
            if (exp_q[(rr_m + k) % P].size() != 0) return (rr_m + k) % P;
        return -1;
    endfunction

    task automatic clear_inputs();
        io.cmd_vld_r   = '0;
        io.flush       = '0;
        io.cmd_out_pop = 1'b0;
        io.ovfl_clr    = 1'b0;
    endtask

    task automatic push(input int p);
        io.cmd_vld_r[p] = 1'b1;
        io.cmd_r[p]     = mk(p, seq);
        seq++;
    endtask

    // Apply the driven inputs to the scoreboard, then advance one clock.
    task automatic tick();
        int g;
        logic [P-1:0] set;
        g   = exp_grant();
        set = '0;
        if (io.cmd_out_pop && g >= 0) begin
            check("pop_vld", 64'(io.cmd_out_vld), 64'd1);
            check("pop_port", 64'(io.cmd_out_port), 64'(g));
            check("pop_cmd", 64'(io.cmd_out), 64'(exp_q[g][0]));
        end
        for (int p = 0; p < P; p++) begin
            if (io.flush[p]) begin
                exp_q[p].delete();
            end else begin
                if (io.cmd_out_pop && g == p) void'(exp_q[p].pop_front());
                if (io.cmd_vld_r[p]) begin
                    if (exp_q[p].size() < N) exp_q[p].push_back(io.cmd_r[p]);
                    else set[p] = 1'b1;
                end
            end
        end
        ovfl_m = set | (ovfl_m & ~{P{io.ovfl_clr}});
        if (io.cmd_out_pop && g >= 0 && !io.flush[g]) rr_m = (g + 1) % P;
        @(posedge clk);
        #1;
        clear_inputs();
    endtask

    task automatic pop_one();
        if (exp_grant() < 0) begin
            check("pop_guard", 64'd0, 64'd1);
        end else begin
            io.cmd_out_pop = 1'b1;
            tick();
        end
    endtask

    task automatic check_state(input string tag);
        int g;
        g = exp_grant();
        for (int p = 0; p < P; p++) begin
            check($sformatf("%s_occ%0d", tag, p), 64'(io.occ_r[p]), 64'(exp_q[p].size()));
            check($sformatf("%s_full%0d", tag, p), 64'(io.cmd_full_r[p]), 64'(exp_q[p].size() >= N - SKID));
            check($sformatf("%s_ovfl%0d", tag, p), 64'(io.ovfl_r[p]), 64'(ovfl_m[p]));
        end
        check({tag, "_vld"}, 64'(io.cmd_out_vld), 64'(g >= 0));
        if (g >= 0) begin
            check({tag, "_port"}, 64'(io.cmd_out_port), 64'(g));
            check({tag, "_cmd"}, 64'(io.cmd_out), 64'(exp_q[g][0]));
        end
    endtask

    task automatic model_reset();
        for (int p = 0; p < P; p++) exp_q[p].delete();
        ovfl_m = '0;
        rr_m   = 0;
    endtask

    task automatic drain();
        for (int i = 0; i < 32 && exp_grant() >= 0; i++) pop_one();
        check("drain_vld", 64'(io.cmd_out_vld), 64'd0);
    endtask

    int ord1 [8] = '{0, 1, 2, 3, 0, 1, 2, 3};
    int ord2 [4] = '{1, 3, 1, 3};
    int bp_full [5] = '{0, 0, 1, 1, 1};
    int bp_occ  [5] = '{1, 2, 3, 4, 4};
    int bp_ovfl [5] = '{0, 0, 0, 0, 1};
    int hold_ports [5] = '{0, 1, 3, 0, 1};

    initial begin
        seq = 0;
        io.cmd_r = '0;
        clear_inputs();
        model_reset();
        rst = 1'b1;
        repeat (2) @(posedge clk);
        #1;
        rst = 1'b0;

        // Reset state
        check("rst_vld", 64'(io.cmd_out_vld), 64'd0);
        check("rst_port", 64'(io.cmd_out_port), 64'd0);
        check("rst_cmd", 64'(io.cmd_out), 64'd0);
        check_state("rst");

        // Fairness: two commands per port, popped in rotating order
        for (int r = 0; r < 2; r++) begin
            for (int p = 0; p < P; p++) push(p);
            tick();
        end
        check_state("fair_load");
        for (int i = 0; i < 8; i++) begin
            check("fair_order", 64'(io.cmd_out_port), 64'(ord1[i]));
            pop_one();
        end
        for (int r = 0; r < 2; r++) begin
            push(1);
            push(3);
            tick();
        end
        for (int i = 0; i < 4; i++) begin
            check("skip_order", 64'(io.cmd_out_port), 64'(ord2[i]));
            pop_one();
        end
        check("fair_empty", 64'(io.cmd_out_vld), 64'd0);

        // Backpressure and overflow on port 2; the 5th push also carries a clear (set wins)
        for (int k = 0; k < 5; k++) begin
            push(2);
            if (k == 4) io.ovfl_clr = 1'b1;
            tick();
            check($sformatf("bp_full_%0d", k + 1), 64'(io.cmd_full_r[2]), 64'(bp_full[k]));
            check($sformatf("bp_occ_%0d", k + 1), 64'(io.occ_r[2]), 64'(bp_occ[k]));
            check($sformatf("bp_ovfl_%0d", k + 1), 64'(io.ovfl_r[2]), 64'(bp_ovfl[k]));
        end
        io.ovfl_clr = 1'b1;
        tick();
        check("bp_ovfl_clr", 64'(io.ovfl_r[2]), 64'd0);
        drain();
        check_state("bp_done");

        // Full port 0 with push and pop in the same cycle
        for (int k = 0; k < N; k++) begin
            push(0);
            tick();
        end
        check("fpp_pre_occ", 64'(io.occ_r[0]), 64'd4);
        push(0);
        io.cmd_out_pop = 1'b1;
        tick();
        check("fpp_occ", 64'(io.occ_r[0]), 64'd4);
        check("fpp_ovfl", 64'(io.ovfl_r[0]), 64'd0);
        check("fpp_full", 64'(io.cmd_full_r[0]), 64'd1);
        drain();

        // Flush of the granted port with a same-cycle push
        push(1);
        push(3);
        tick();
        push(1);
        tick();
        push(1);
        tick();
        check("fl_pre_port", 64'(io.cmd_out_port), 64'd1);
        check("fl_pre_occ", 64'(io.occ_r[1]), 64'd3);
        io.flush[1] = 1'b1;
        push(1);
        tick();
        check("fl_occ", 64'(io.occ_r[1]), 64'd0);
        check("fl_vld", 64'(io.cmd_out_vld), 64'd1);
        check("fl_port", 64'(io.cmd_out_port), 64'd3);
        check_state("fl");
        drain();

        // Hold: grant sits at the rr pointer, later ports keep receiving pushes
        push(1);
        tick();
        pop_one();
        push(2);
        tick();
        hold_cmd = exp_q[2][0];
        for (int k = 0; k < 5; k++) begin
            push(hold_ports[k]);
            tick();
            check("hold_vld", 64'(io.cmd_out_vld), 64'd1);
            check("hold_port", 64'(io.cmd_out_port), 64'd2);
            check("hold_cmd", 64'(io.cmd_out), 64'(hold_cmd));
        end
        check_state("hold");
        drain();

        // Reset in the middle of traffic
        push(0);
        push(2);
        tick();
        push(1);
        push(3);
        rst = 1'b1;
        @(posedge clk);
        #1;
        rst = 1'b0;
        clear_inputs();
        model_reset();
        check("mid_rst_vld", 64'(io.cmd_out_vld), 64'd0);
        check_state("mid_rst");

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL timeout: got running expected finished");
        $fatal(1, "timeout");
    end

endmodule
